initial_perm_loader: RTL and testbench
======================================

INITIAL_PERM_LOADER -- requirements
Module: initial_perm_loader

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning: 1 = first accepted byte is block bits [63:56]; 0 = first byte is bits [7:0].
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port byte_in, input, 8 bits: plaintext/ciphertext byte.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-006 SHALL have port byte_ready, output, 1 bit: loader can accept a byte.
REQ-007 SHALL have port clr, input, 1 bit: synchronous abort of a partially loaded block.
REQ-008 SHALL have port l0, output, 32 bits: left half after the initial permutation (IP output bits [63:32]).
REQ-009 SHALL have port r0, output, 32 bits: right half after the initial permutation (IP output bits [31:0]).
REQ-010 SHALL have port blk_valid, output, 1 bit: l0/r0 hold a valid permuted block.
REQ-011 SHALL have port blk_ready, input, 1 bit: downstream round datapath accepts l0/r0.
REQ-012 SHALL have port busy, output, 1 bit: partial or full block held in the assembly register.

Function
REQ-013 SHALL hold a 64-bit assembly register asm_q and a byte counter cnt (range 0..8).
REQ-014 SHALL drive byte_ready = (cnt < 8); a byte SHALL be accepted on an edge where byte_valid && byte_ready && !clr.
REQ-015 SHALL, on accept with MSB_FIRST=1, shift asm_q left 8 bits and insert byte_in at [7:0], so that after 8 bytes the first byte sits at [63:56]; with MSB_FIRST=0, the first byte SHALL land at [7:0] and the eighth at [63:56].
REQ-016 SHALL increment cnt by 1 on each accepted byte; cnt SHALL never exceed 8.
REQ-017 SHALL apply the standard DES initial permutation (the inverse of the final permutation), using DES bit numbering where bit 1 = vector bit 63: output bit (64-i) = asm_q bit (64-IP[i]).
REQ-018 SHALL use IP table rows: 58 50 42 34 26 18 10 2 / 60 52 44 36 28 20 12 4 / 62 54 46 38 30 22 14 6 / 64 56 48 40 32 24 16 8 / 57 49 41 33 25 17 9 1 / 59 51 43 35 27 19 11 3 / 61 53 45 37 29 21 13 5 / 63 55 47 39 31 23 15 7.
REQ-019 SHALL perform a load when cnt == 8 && (!blk_valid || blk_ready): register IP(asm_q) into {l0, r0}, set blk_valid to 1, and set cnt to 0, all on the same edge.
REQ-020 SHALL give the following latency: the 8th byte is accepted at edge N; blk_valid is high after edge N+1 when the output is free. Best-case throughput is one block per 9 cycles.
REQ-021 SHALL clear blk_valid on an edge with blk_valid && blk_ready unless a load occurs on that edge; a load SHALL take precedence and keep blk_valid at 1.
REQ-022 SHALL hold l0/r0 stable while blk_valid && !blk_ready.
REQ-023 SHALL, when cnt == 8 and the output is stalled, keep byte_ready low and preserve asm_q unchanged.
REQ-024 SHALL, on clr, set cnt to 0 and discard any byte presented on that edge; clr SHALL NOT alter l0, r0 or blk_valid, and SHALL NOT suppress a load occurring on the same edge.
REQ-025 SHALL drive busy = (cnt != 0).

Reset
REQ-026 SHALL, while rst_n is low, asynchronously set cnt=0, asm_q=0, l0=0, r0=0 and blk_valid=0, which gives byte_ready=1 and busy=0.
REQ-027 SHALL discard any partial block and any undelivered output on reset; loading SHALL resume with byte 1 on the first edge after rst_n rises.

Verification
REQ-028 SHALL verify: MSB_FIRST=1, bytes 01 23 45 67 89 AB CD EF, blk_ready=1 -> l0=CC00CCFF, r0=F0AAF0AA, blk_valid high one cycle after the 8th byte.
REQ-029 SHALL verify: bytes 80 00 00 00 00 00 00 00 -> l0=00000000, r0=01000000; all-zero bytes -> l0=r0=0.
REQ-030 SHALL verify: blk_ready=0 while two blocks stream in -> block 1 held stable, byte_ready low after block 2's 8th byte; raise blk_ready -> block 1 accepted, block 2 appears the next cycle with blk_valid continuously high.
REQ-031 SHALL verify: clr after 3 bytes, then 8 new bytes -> output reflects only the new 8 bytes; l0/r0 from the prior block unchanged until the load.
REQ-032 SHALL verify: rst_n low after 5 bytes with blk_valid=1 -> blk_valid=0, busy=0, l0=r0=0 immediately (asynchronously); the next 8 bytes produce a correct block.
REQ-033 SHALL verify: MSB_FIRST=0, bytes EF CD AB 89 67 45 23 01 -> l0=CC00CCFF, r0=F0AAF0AA; FP(IP(x)) == x for 1000 random blocks.

Source files
------------

// File: rtl/initial_perm_loader.sv
// initial_perm_loader: assembles eight bytes into a 64-bit DES block,
// applies the DES initial permutation and presents the two 32-bit halves
// (l0, r0) to the round datapath.
//
// Handshakes: both ports use valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. The producer must hold its
// payload stable while valid is high and ready is low. On the input side,
// clr has priority: a byte presented on a clr edge is dropped.
module initial_perm_loader #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        clr,
  output logic [31:0] l0,
  output logic [31:0] r0,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        busy
);

  // DES initial permutation. Entry i (0-based) names the DES input bit
  // (1 = vector bit 63) that lands on DES output bit i+1.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  function automatic logic [63:0] des_ip(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[6'(63 - i)] = d[6'(64 - IP_TAB[i])];
    end
    return o;
  endfunction

  logic [63:0] asm_q;
  logic [63:0] asm_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        load;
  logic [63:0] perm;

  assign byte_ready = (cnt < 4'd8);
  assign busy       = (cnt != 4'd0);
  assign accept     = byte_valid && byte_ready && !clr;
  // A full block moves out when the output register is empty or is being
  // drained on this same edge.
  assign load       = (cnt == 4'd8) && (!blk_valid || blk_ready);
  assign perm       = des_ip(asm_q);

  // Next assembly value: bytes enter at the low end and move up (MSB-first),
  // or enter at the high end and move down (LSB-first).
  always_comb begin
    asm_next = asm_q;
    if (MSB_FIRST != 0) begin
      asm_next = {asm_q[55:0], byte_in};
    end else begin
      asm_next = {byte_in, asm_q[63:8]};
    end
  end

  // Byte counter and assembly register. A load or clr restarts the count;
  // asm_q only changes on an accepted byte, so it is frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      asm_q <= 64'd0;
    end else begin
      if (load || clr) begin
        cnt <= 4'd0;
      end else if (accept) begin
        cnt <= cnt + 4'd1;
      end
      if (accept) begin
        asm_q <= asm_next;
      end
    end
  end

  // Output register: a load wins over a drain so back-to-back blocks keep
  // blk_valid high; clr never touches this register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l0        <= 32'd0;
      r0        <= 32'd0;
      blk_valid <= 1'b0;
    end else begin
      if (load) begin
        l0        <= perm[63:32];
        r0        <= perm[31:0];
        blk_valid <= 1'b1;
      end else if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_initial_perm_loader.sv
// Testbench for initial_perm_loader: directed blocks with hand-computed
// permutation results, stall/clear/reset scenarios, an LSB-first instance,
// and a random round trip through the DES final permutation.
module tb_initial_perm_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // MSB-first instance
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        clr;
  logic [31:0] l0;
  logic [31:0] r0;
  logic        blk_valid;
  logic        blk_ready;
  logic        busy;

  // LSB-first instance
  logic [7:0]  byte_in_b;
  logic        byte_valid_b;
  logic        byte_ready_b;
  logic        clr_b;
  logic [31:0] l0_b;
  logic [31:0] r0_b;
  logic        blk_valid_b;
  logic        blk_ready_b;
  logic        busy_b;

  initial_perm_loader #(.MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .clr(clr), .l0(l0), .r0(r0),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .busy(busy)
  );

  initial_perm_loader #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in_b), .byte_valid(byte_valid_b),
    .byte_ready(byte_ready_b), .clr(clr_b), .l0(l0_b), .r0(r0_b),
    .blk_valid(blk_valid_b), .blk_ready(blk_ready_b), .busy(busy_b)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic        kind_q[$];   // 0: compare {l0,r0} directly, 1: compare FP({l0,r0})
  logic [63:0] mon_exp;
  logic        mon_kind;

  // DES final permutation, independent of the DUT's table.
  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] des_fp(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[6'(63 - i)] = d[6'(64 - FP_TAB[i])];
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples on the falling edge: a block present with blk_ready high is
  // transferred on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_block: got %h expected none", {l0, r0});
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        if (mon_kind) check("roundtrip", des_fp({l0, r0}), mon_exp);
        else          check("block", {l0, r0}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] x);
    for (int i = 0; i < 8; i++) send_byte(x[63 - 8*i -: 8]);
  endtask

  task automatic expect_block(input logic [63:0] e, input logic k);
    exp_q.push_back(e);
    kind_q.push_back(k);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] x;
    int n;
    rst_n = 1'b0;
    byte_in = 8'd0; byte_valid = 1'b0; clr = 1'b0; blk_ready = 1'b1;
    byte_in_b = 8'd0; byte_valid_b = 1'b0; clr_b = 1'b0; blk_ready_b = 1'b1;
    cycles(2);

    // reset state
    check("rst_byte_ready", 64'(byte_ready), 64'd1);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_blk_valid",  64'(blk_valid),  64'd0);
    check("rst_l0r0",       {l0, r0},        64'd0);
    rst_n = 1'b1;

    // known vector and latency
    expect_block(64'hCC00CCFF_F0AAF0AA, 1'b0);
    send_block(64'h0123456789ABCDEF);
    check("lat_before", 64'(blk_valid), 64'd0);
    cycles(1);
    check("lat_after", 64'(blk_valid), 64'd1);
    cycles(1);
    check("valid_drop", 64'(blk_valid), 64'd0);

    // single bit and all zero
    expect_block(64'h00000000_01000000, 1'b0);
    send_block(64'h8000000000000000);
    expect_block(64'h0, 1'b0);
    send_block(64'h0);
    cycles(3);

    // stalled output with two blocks
    blk_ready = 1'b0;
    expect_block(64'hCC00CCFF_F0AAF0AA, 1'b0);
    expect_block(64'h00000000_01000000, 1'b0);
    send_block(64'h0123456789ABCDEF);
    send_block(64'h8000000000000000);
    check("stall_byte_ready", 64'(byte_ready), 64'd0);
    check("stall_busy",       64'(busy),       64'd1);
    check("stall_hold",       {l0, r0},        64'hCC00CCFF_F0AAF0AA);
    cycles(3);
    check("stall_byte_ready2", 64'(byte_ready), 64'd0);
    check("stall_hold2",       {l0, r0},        64'hCC00CCFF_F0AAF0AA);
    check("stall_valid",       64'(blk_valid),  64'd1);
    blk_ready = 1'b1;
    cycles(1);
    check("b2b_valid", 64'(blk_valid), 64'd1);
    check("b2b_data",  {l0, r0},       64'h00000000_01000000);
    cycles(1);
    check("b2b_drop", 64'(blk_valid), 64'd0);

    // clear after three bytes, with a byte presented on the clr edge
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    byte_in = 8'hAA; byte_valid = 1'b1; clr = 1'b1;
    cycles(1);
    clr = 1'b0; byte_valid = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_keep", {l0, r0},  64'h00000000_01000000);
    expect_block(64'hCC00CCFF_F0AAF0AA, 1'b0);
    send_block(64'h0123456789ABCDEF);
    check("pre_load_keep", {l0, r0}, 64'h00000000_01000000);
    cycles(3);

    // asynchronous reset with a held block and a partial block
    blk_ready = 1'b0;
    send_block(64'h0123456789ABCDEF);
    cycles(1);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    check("pre_rst_valid", 64'(blk_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid",      64'(blk_valid),  64'd0);
    check("arst_busy",       64'(busy),       64'd0);
    check("arst_l0r0",       {l0, r0},        64'd0);
    check("arst_byte_ready", 64'(byte_ready), 64'd1);
    cycles(2);
    rst_n = 1'b1;
    blk_ready = 1'b1;
    expect_block(64'h00000000_01000000, 1'b0);
    send_block(64'h8000000000000000);
    cycles(3);

    // LSB-first instance
    x = 64'hEFCDAB8967452301;
    for (int i = 0; i < 8; i++) begin
      byte_in_b = x[63 - 8*i -: 8];
      byte_valid_b = 1'b1;
      cycles(1);
    end
    byte_valid_b = 1'b0;
    n = 0;
    while (!blk_valid_b && n < 20) begin
      cycles(1);
      n++;
    end
    check("lsb_valid", 64'(blk_valid_b), 64'd1);
    check("lsb_block", {l0_b, r0_b},     64'hCC00CCFF_F0AAF0AA);

    // random round trip through the final permutation
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      expect_block(x, 1'b1);
      send_block(x);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
